// File: rtl/uart_parity_engine.sv
// Serial parity unit shared by UART TX and RX. It accumulates parity over 5..MAX_DATA_BITS
// strobed data bits and then presents the parity slot bit or checks the received one.
module uart_parity_engine #(
    parameter int MAX_DATA_BITS = 9,
    parameter int CNT_W         = $clog2(MAX_DATA_BITS + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       bit_valid_i,
    input  logic       bit_i,
    input  logic [3:0] data_bits_i,
    input  logic [2:0] parity_mode_i,
    input  logic       check_valid_i,
    input  logic       check_bit_i,
    output logic       parity_bit_o,
    output logic       parity_ready_o,
    output logic       parity_err_o,
    output logic       frame_done_o,
    output logic       busy_o,
    output logic       restart_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam logic [2:0] MODE_EVEN  = 3'd1;
    localparam logic [2:0] MODE_ODD   = 3'd2;
    localparam logic [2:0] MODE_MARK  = 3'd3;
    localparam logic [2:0] MODE_SPACE = 3'd4;

    localparam logic [3:0]       MIN_LEN = 4'd5;
    localparam logic [3:0]       MAX_LEN = 4'(MAX_DATA_BITS);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state_reg, state_next;
    logic             acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] len_reg, len_next;
    logic [2:0]       mode_reg, mode_next;
    logic             parity_bit_reg, parity_bit_next;
    logic             ready_reg, ready_next;
    logic             err_reg, err_next;
    logic             done_reg, done_next;
    logic             busy_reg, busy_next;
    logic             restart_reg, restart_next;

    logic [3:0]       len_clamped;
    logic             acc_final;
    logic             mode_is_none;

    always_comb begin
        if (data_bits_i < MIN_LEN)
            len_clamped = MIN_LEN;
        else if (data_bits_i > MAX_LEN)
            len_clamped = MAX_LEN;
        else
            len_clamped = data_bits_i;
    end

    // Codes 5..7 behave exactly like "none".
    assign mode_is_none = (mode_reg == 3'd0) || (mode_reg > MODE_SPACE);
    assign acc_final    = acc_reg ^ bit_i;

    always_comb begin
        state_next      = state_reg;
        acc_next        = acc_reg;
        cnt_next        = cnt_reg;
        len_next        = len_reg;
        mode_next       = mode_reg;
        parity_bit_next = parity_bit_reg;
        err_next        = 1'b0;
        done_next       = 1'b0;
        restart_next    = 1'b0;

        if (abort_i) begin
            state_next      = IDLE;
            acc_next        = 1'b0;
            cnt_next        = '0;
            parity_bit_next = 1'b1;
        end else if (start_i) begin
            state_next      = ACCUM;
            acc_next        = 1'b0;
            cnt_next        = '0;
            len_next        = CNT_W'(len_clamped);
            mode_next       = parity_mode_i;
            parity_bit_next = 1'b1;
            restart_next    = (state_reg != IDLE);
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (bit_valid_i) begin
                        acc_next = acc_final;
                        cnt_next = cnt_reg + ONE;
                        // The final strobe always leaves ACCUM, so the counter cannot pass len.
                        if (cnt_reg == len_reg - ONE) begin
                            if (mode_is_none) begin
                                state_next = IDLE;
                                done_next  = 1'b1;
                            end else begin
                                state_next = PARITY;
                                case (mode_reg)
                                    MODE_EVEN:  parity_bit_next = acc_final;
                                    MODE_ODD:   parity_bit_next = ~acc_final;
                                    MODE_MARK:  parity_bit_next = 1'b1;
                                    default:    parity_bit_next = 1'b0;
                                endcase
                            end
                        end
                    end
                end
                PARITY: begin
                    if (check_valid_i) begin
                        state_next      = IDLE;
                        err_next        = (check_bit_i != parity_bit_reg);
                        done_next       = 1'b1;
                        parity_bit_next = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        ready_next = (state_next == PARITY);
        busy_next  = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            acc_reg        <= 1'b0;
            cnt_reg        <= '0;
            len_reg        <= CNT_W'(MIN_LEN);
            mode_reg       <= 3'd0;
            parity_bit_reg <= 1'b1;
            ready_reg      <= 1'b0;
            err_reg        <= 1'b0;
            done_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            restart_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            acc_reg        <= acc_next;
            cnt_reg        <= cnt_next;
            len_reg        <= len_next;
            mode_reg       <= mode_next;
            parity_bit_reg <= parity_bit_next;
            ready_reg      <= ready_next;
            err_reg        <= err_next;
            done_reg       <= done_next;
            busy_reg       <= busy_next;
            restart_reg    <= restart_next;
        end
    end

    assign parity_bit_o   = parity_bit_reg;
    assign parity_ready_o = ready_reg;
    assign parity_err_o   = err_reg;
    assign frame_done_o   = done_reg;
    assign busy_o         = busy_reg;
    assign restart_o      = restart_reg;

endmodule

// File: tb/tb_uart_parity_engine.sv
// Self-checking bench for uart_parity_engine: a vector table of whole frames checked through
// a scoreboard queue, plus hand-written sequences for errors, abort, restart and reset.
module tb_uart_parity_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i, abort_i, bit_valid_i, bit_i;
    logic [3:0] data_bits_i;
    logic [2:0] parity_mode_i;
    logic       check_valid_i, check_bit_i;
    logic       parity_bit_o, parity_ready_o, parity_err_o, frame_done_o, busy_o, restart_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  db;
        logic [2:0]  mode;
        logic [15:0] data;
        int          n;
        logic        pbit;
        logic        ready;
    } vec_t;

    typedef struct {
        logic pbit;
        logic ready;
        logic done;
    } exp_t;

    vec_t vecs[14];
    exp_t sb[$];

    uart_parity_engine #(.MAX_DATA_BITS(9)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .bit_valid_i    (bit_valid_i),
        .bit_i          (bit_i),
        .data_bits_i    (data_bits_i),
        .parity_mode_i  (parity_mode_i),
        .check_valid_i  (check_valid_i),
        .check_bit_i    (check_bit_i),
        .parity_bit_o   (parity_bit_o),
        .parity_ready_o (parity_ready_o),
        .parity_err_o   (parity_err_o),
        .frame_done_o   (frame_done_o),
        .busy_o         (busy_o),
        .restart_o      (restart_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] db, input logic [2:0] mode);
        start_i       = 1'b1;
        data_bits_i   = db;
        parity_mode_i = mode;
        step();
        start_i       = 1'b0;
        // Scramble config to show only the start-cycle value matters.
        data_bits_i   = 4'($urandom);
        parity_mode_i = 3'($urandom);
    endtask

    task automatic send_bits(input logic [15:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            bit_valid_i = 1'b1;
            bit_i       = data[i];
            step();
            bit_valid_i = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        int   n;
        do_start(v.db, v.mode);
        chk("start_restart", restart_o, 1'b0);
        chk("start_busy", busy_o, 1'b1);
        for (int i = 0; i < v.n; i++) begin
            bit_valid_i   = 1'b1;
            bit_i         = v.data[i];
            check_valid_i = (i == 0);
            check_bit_i   = ~v.pbit;
            if (i == v.n - 1) sb.push_back('{v.pbit, v.ready, !v.ready});
            step();
            bit_valid_i   = 1'b0;
            check_valid_i = 1'b0;
            if (i < v.n - 1) begin
                chk("early_ready", parity_ready_o, 1'b0);
                chk("early_done", frame_done_o, 1'b0);
                chk("accum_err", parity_err_o, 1'b0);
            end
        end
        n = 0;
        while (!(parity_ready_o || frame_done_o) && n < 8) begin
            step();
            n++;
        end
        chk_int("latency", n, 0);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1'b1, 1'b0);
            return;
        end
        e = sb.pop_front();
        chk("ready", parity_ready_o, e.ready);
        chk("pbit", parity_bit_o, e.pbit);
        chk("done", frame_done_o, e.done);
        chk("err", parity_err_o, 1'b0);
        $display("vec %0d: db=%0d mode=%0d data=%h -> pbit=%b ready=%b done=%b",
                 idx, v.db, v.mode, v.data, parity_bit_o, parity_ready_o, frame_done_o);
        if (v.ready) begin
            bit_valid_i = 1'b1;
            bit_i       = 1'b1;
            step();
            bit_valid_i = 1'b0;
            chk("hold_ready", parity_ready_o, 1'b1);
            chk("hold_pbit", parity_bit_o, v.pbit);
            check_valid_i = 1'b1;
            check_bit_i   = v.pbit;
            step();
            check_valid_i = 1'b0;
            chk("close_done", frame_done_o, 1'b1);
            chk("close_err", parity_err_o, 1'b0);
            chk("close_ready", parity_ready_o, 1'b0);
            chk("close_pbit", parity_bit_o, 1'b1);
            chk("close_busy", busy_o, 1'b0);
            step();
            chk("close_done_drop", frame_done_o, 1'b0);
        end else begin
            step();
            chk("none_done_drop", frame_done_o, 1'b0);
            chk("none_busy", busy_o, 1'b0);
            chk("none_pbit", parity_bit_o, 1'b1);
        end
    endtask

    initial begin
        vecs[0]  = '{4'd8,  3'd1, 16'h00A5, 8, 1'b0, 1'b1};
        vecs[1]  = '{4'd8,  3'd2, 16'h00A5, 8, 1'b1, 1'b1};
        vecs[2]  = '{4'd8,  3'd3, 16'h00A5, 8, 1'b1, 1'b1};
        vecs[3]  = '{4'd8,  3'd4, 16'h00A5, 8, 1'b0, 1'b1};
        vecs[4]  = '{4'd8,  3'd1, 16'h00A4, 8, 1'b1, 1'b1};
        vecs[5]  = '{4'd8,  3'd2, 16'h00A4, 8, 1'b0, 1'b1};
        vecs[6]  = '{4'd8,  3'd0, 16'h00A5, 8, 1'b1, 1'b0};
        vecs[7]  = '{4'd3,  3'd1, 16'h0013, 5, 1'b1, 1'b1};
        vecs[8]  = '{4'd12, 3'd1, 16'h0155, 9, 1'b1, 1'b1};
        vecs[9]  = '{4'd15, 3'd2, 16'h0100, 9, 1'b0, 1'b1};
        vecs[10] = '{4'd0,  3'd4, 16'h001F, 5, 1'b0, 1'b1};
        vecs[11] = '{4'd5,  3'd5, 16'h001F, 5, 1'b1, 1'b0};
        vecs[12] = '{4'd7,  3'd7, 16'h0001, 7, 1'b1, 1'b0};
        vecs[13] = '{4'd6,  3'd3, 16'h0000, 6, 1'b1, 1'b1};

        rst = 1'b0;
        start_i = 0; abort_i = 0; bit_valid_i = 0; bit_i = 0;
        data_bits_i = 0; parity_mode_i = 0; check_valid_i = 0; check_bit_i = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pbit", parity_bit_o, 1'b1);
        chk("rst_ready", parity_ready_o, 1'b0);
        chk("rst_err", parity_err_o, 1'b0);
        chk("rst_done", frame_done_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_restart", restart_o, 1'b0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // Received parity mismatch, then a matching one.
        for (int k = 0; k < 2; k++) begin
            do_start(4'd7, 3'd1);
            send_bits(16'h007F, 7);
            chk("err_seq_pbit", parity_bit_o, 1'b1);
            check_valid_i = 1'b1;
            check_bit_i   = (k == 1);
            step();
            check_valid_i = 1'b0;
            chk("err_seq_err", parity_err_o, (k == 0));
            chk("err_seq_done", frame_done_o, 1'b1);
            chk("err_seq_busy", busy_o, 1'b0);
            step();
            chk("err_seq_err_drop", parity_err_o, 1'b0);
            chk("err_seq_done_drop", frame_done_o, 1'b0);
            $display("rx check k=%0d: check_bit=%0d", k, k);
        end

        // Abort after four bits, then strobes in IDLE are ignored.
        do_start(4'd8, 3'd1);
        send_bits(16'h000F, 4);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("abort_busy", busy_o, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bit_valid_i = 1'b1;
            bit_i       = 1'b1;
            step();
            chk("abort_done", frame_done_o, 1'b0);
            chk("abort_err", parity_err_o, 1'b0);
            chk("abort_ready", parity_ready_o, 1'b0);
        end
        bit_valid_i = 1'b0;
        $display("abort after 4 bits: busy=%b", busy_o);

        // Restart mid-frame clears the accumulator.
        do_start(4'd8, 3'd1);
        send_bits(16'h0007, 4);
        do_start(4'd8, 3'd1);
        chk("restart_pulse", restart_o, 1'b1);
        chk("restart_busy", busy_o, 1'b1);
        send_bits(16'h00A5, 1);
        chk("restart_drop", restart_o, 1'b0);
        send_bits(16'h0052, 7);
        chk("restart_ready", parity_ready_o, 1'b1);
        chk("restart_pbit", parity_bit_o, 1'b0);
        $display("restart: pbit=%b ready=%b", parity_bit_o, parity_ready_o);

        // Abort wins over a simultaneous start.
        abort_i = 1'b1;
        start_i = 1'b1;
        step();
        abort_i = 1'b0;
        start_i = 1'b0;
        chk("abort_start_busy", busy_o, 1'b0);
        chk("abort_start_restart", restart_o, 1'b0);
        chk("abort_start_pbit", parity_bit_o, 1'b1);

        // Reset asserted while in PARITY acts immediately.
        do_start(4'd8, 3'd2);
        send_bits(16'h00A4, 8);
        chk("pre_rst_pbit", parity_bit_o, 1'b0);
        rst = 1'b0;
        #1;
        chk("async_rst_pbit", parity_bit_o, 1'b1);
        chk("async_rst_ready", parity_ready_o, 1'b0);
        chk("async_rst_busy", busy_o, 1'b0);
        step();
        rst = 1'b1;
        step();
        chk("post_rst_busy", busy_o, 1'b0);
        $display("reset in PARITY: pbit=%b ready=%b", parity_bit_o, parity_ready_o);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
